// File: rtl/encoder_8_3_seq_if.sv
// Handshake bundle for encoder_8_3_seq: request vector in, 3-bit codes out.
interface encoder_8_3_seq_if;
  logic [7:0] in;
  logic       in_valid;
  logic       in_ready;
  logic       a;
  logic       b;
  logic       c;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] remain;
  logic       err_zero;

  // Source/consumer side
  modport master (
    output in, in_valid, code_ready,
    input  in_ready, a, b, c, code_valid, remain, err_zero
  );

  // Encoder side
  modport slave (
    input  in, in_valid, code_ready,
    output in_ready, a, b, c, code_valid, remain, err_zero
  );
endinterface

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 priority encoder: latches a request vector and emits the
// index of every set bit, one per code handshake, in priority order.
module encoder_8_3_seq #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  encoder_8_3_seq_if.slave   bus
);

  localparam int unsigned VEC_W  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   pend;
  logic [CODE_W-1:0]  code;
  logic               code_valid;
  logic [CNT_W-1:0]   remain;
  logic               err_zero;

  logic [CODE_W-1:0]  in_idx;
  logic [CNT_W-1:0]   in_cnt;
  logic [VEC_W-1:0]   pend_nxt;
  logic [CODE_W-1:0]  nxt_idx;

  // Index of the highest-priority set bit; 0 for an empty vector
  function automatic logic [CODE_W-1:0] pick_idx(input logic [VEC_W-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(VEC_W); i++) begin
        if (v[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
        if (v[i]) idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [VEC_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(VEC_W); i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    in_idx   = pick_idx(bus.in);
    in_cnt   = popcnt(bus.in);
    pend_nxt = pend & ~(VEC_W'(1) << code);
    nxt_idx  = pick_idx(pend_nxt);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      pend       <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      remain     <= '0;
      err_zero   <= 1'b0;
    end else begin
      err_zero <= 1'b0;
      case (state)
        IDLE: begin
          code_valid <= 1'b0;
          if (bus.in_valid) begin
            if (bus.in != '0) begin
              pend       <= bus.in;
              code       <= in_idx;
              remain     <= in_cnt;
              code_valid <= 1'b1;
              state      <= OUT;
            end else begin
              err_zero <= 1'b1;
            end
          end
        end
        OUT: begin
          if (code_valid && bus.code_ready) begin
            if (pend_nxt != '0) begin
              pend   <= pend_nxt;
              code   <= nxt_idx;
              remain <= remain - CNT_W'(1);
            end else begin
              // Last code taken: code holds its final value
              pend       <= '0;
              remain     <= '0;
              code_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.a          = code[2];
  assign bus.b          = code[1];
  assign bus.c          = code[0];
  assign bus.code_valid = code_valid;
  assign bus.remain     = remain;
  assign bus.err_zero   = err_zero;

endmodule

// File: doc/encoder_8_3_seq.md
Name: encoder_8_3_seq

Overview:
- Sequential 8-to-3 priority encoder; the inverse of the team's decoder_3_8.
- Accepts an 8-bit request vector over a valid/ready handshake and latches it as a pending set.
- Emits the 3-bit index {a,b,c} of each set bit, one per handshake, in priority order, then returns to idle.
- Feeds decoder_3_8-style consumers: a is the code MSB, c the LSB.

Parameters:
- MSB_FIRST, 1: 1 = bit 7 has highest priority; 0 = bit 0 has highest priority.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst_n  input  1  synchronous reset, active low.
- in  input  8  request vector.
- in_valid  input  1  in is valid this cycle.
- in_ready  output  1  block can accept a vector (IDLE only).
- a  output  1  code bit 2 (MSB).
- b  output  1  code bit 1.
- c  output  1  code bit 0 (LSB).
- code_valid  output  1  {a,b,c} holds a valid code.
- code_ready  input  1  consumer accepts the current code.
- remain  output  4  pending codes including the current one (0..8).
- err_zero  output  1  one-cycle pulse when an all-zero vector is accepted.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst_n is synchronous and active-low.
- All outputs are registered except in_ready, which is decoded from state: in_ready = (state==IDLE).
- Reset (sys_rst_n=0 at a rising edge):
  - state=IDLE, pend=8'h00, {a,b,c}=3'b000, code_valid=0, remain=0, err_zero=0; in_ready=1 from the following cycle.
  - Reset overrides any in-flight vector or handshake; pending bits are discarded with no further codes.
- State IDLE:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Transfer with in!=0: pend<=in; {a,b,c}<=index of highest-priority set bit of in; remain<=popcount(in); code_valid<=1; go to OUT.
  - Transfer with in==0: vector dropped; err_zero<=1 for exactly one cycle; stay IDLE.
  - No transfer: outputs hold; code_valid=0.
- State OUT:
  - in_ready=0; in/in_valid ignored.
  - Code transfer = code_valid && code_ready at a rising edge. It clears the current bit from pend and decrements remain.
  - If bits remain: {a,b,c}<=index of the next-priority bit; code_valid stays 1. Throughput is 1 code/cycle with code_ready held high.
  - If none remain: code_valid<=0, remain<=0, go to IDLE. {a,b,c} holds its last value.
  - Without code_ready, {a,b,c}, remain and code_valid are held stable.
- Latency:
  - Vector accepted at edge N: first code is visible in the cycle after edge N.
  - Last code accepted at edge M: in_ready=1 and code_valid=0 in the cycle after edge M.
  - Minimum IDLE-to-IDLE time for k set bits is k+1 cycles. At least one IDLE cycle separates vectors.
- Priority select:
  - MSB_FIRST=1: the highest index set bit is chosen first.
  - MSB_FIRST=0: the lowest index set bit is chosen first.
  - in=8'hFF produces all 8 codes, remain starting at 8.
- Simultaneous events:
  - code_ready is a don't-care while code_valid=0.
  - in_valid during OUT is not accepted and not buffered; the source must hold it until in_ready.

Test Plan:
- Reset: hold sys_rst_n=0 for 3 cycles, then release -> code_valid=0, {a,b,c}=000, remain=0, err_zero=0, in_ready=1.
- Single bit: in=8'b0000_0100, in_valid=1 for 1 cycle, code_ready=1 -> next cycle {a,b,c}=010, remain=1, code_valid=1; one cycle later code_valid=0, in_ready=1.
- Multi bit, MSB_FIRST=1: in=8'b1010_0001, code_ready=1 -> codes 111, 101, 000 on consecutive cycles with remain 3, 2, 1; then IDLE.
- Backpressure: same vector, code_ready=0 for 5 cycles -> {a,b,c}=111 and remain=3 held stable; when code_ready rises, the sequence continues as above.
- Zero input and ordering:
  - in=8'h00 accepted -> err_zero=1 for exactly one cycle, code_valid stays 0.
  - MSB_FIRST=0 with in=8'b1010_0001 -> codes 000, 101, 111.
- Mid-operation reset: in=8'hFF, pull sys_rst_n low after 3 codes -> next cycle code_valid=0, remain=0, in_ready=1; a new in=8'h10 yields 100 only.
